// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: picks between ALU and memory writebacks,
// registers the winning write onto the single rf port (x0 writes dropped),
// and tracks outstanding destination registers in a pending scoreboard.
module rf_write_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_wd,
  output logic            mem_ready,
  input  logic            rsv_valid,
  input  logic [4:0]      rsv_rd,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     pending,
  output logic            err_double_rsv
);

  logic [3:0]      streak;
  logic            contested;
  logic            streak_max;
  logic            acc_p0;
  logic [4:0]      acc_rd_p0;
  logic [XLEN-1:0] acc_wd_p0;
  logic            wr_nz_p0;
  logic [31:0]     clr_mask;
  logic [31:0]     set_mask;
  logic            rsv_dup;

  logic            vld_p1;
  logic [4:0]      rd_p1;
  logic [XLEN-1:0] wd_p1;
  logic [31:0]     pending_q;
  logic            err_q;

  // Grant logic: memory wins contested cycles until it has won MAX_STREAK in a row.
  always_comb begin
    contested  = alu_valid & mem_valid;
    streak_max = (streak == 4'(MAX_STREAK));
    alu_ready  = ~rst & alu_valid & (~mem_valid | streak_max);
    mem_ready  = ~rst & mem_valid & (~alu_valid | ~streak_max);
    acc_p0     = alu_ready | mem_ready;
    acc_rd_p0  = alu_ready ? alu_rd : mem_rd;
    acc_wd_p0  = alu_ready ? alu_wd : mem_wd;
    wr_nz_p0   = acc_p0 & (acc_rd_p0 != 5'd0);
  end

  // Scoreboard update masks; a same-cycle set of a register overrides its clear.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wr_nz_p0)
      clr_mask[acc_rd_p0] = 1'b1;
    if (rsv_valid && rsv_rd != 5'd0)
      set_mask[rsv_rd] = 1'b1;
    rsv_dup = rsv_valid && (rsv_rd != 5'd0) && pending_q[rsv_rd] &&
              !(wr_nz_p0 && acc_rd_p0 == rsv_rd);
  end

  // ---- stage p0 -> p1: accepted write lands on the register-file port ----
  // Register the winning write, scoreboard, error flag and fairness streak.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      rd_p1     <= '0;
      wd_p1     <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
      streak    <= '0;
    end else begin
      vld_p1 <= wr_nz_p0;
      if (wr_nz_p0) begin
        rd_p1 <= acc_rd_p0;
        wd_p1 <= acc_wd_p0;
      end
      pending_q <= (pending_q & ~clr_mask) | set_mask;
      if (rsv_dup)
        err_q <= 1'b1;
      if (alu_ready)
        streak <= '0;
      else if (mem_ready && contested && !streak_max)
        streak <= streak + 4'd1;
    end
  end

  assign rf_we          = vld_p1;
  assign rf_rd          = rd_p1;
  assign rf_wd          = wd_p1;
  assign pending        = pending_q;
  assign err_double_rsv = err_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, mem_valid, rsv_valid;
  logic [4:0]      alu_rd, mem_rd, rsv_rd;
  logic [XLEN-1:0] alu_wd, mem_wd;
  logic            alu_ready, mem_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [31:0]     pending;
  logic            err_double_rsv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.MAX_STREAK(4), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .pending(pending), .err_double_rsv(err_double_rsv)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; rsv_valid = 0;
    alu_rd = 0; mem_rd = 0; rsv_rd = 0; alu_wd = 0; mem_wd = 0;
  endtask

  logic exp_alu;

  initial begin
    idle();
    rst = 1;
    step();

    // reset mid-write
    alu_valid = 1; alu_rd = 5; alu_wd = 32'h11;
    rsv_valid = 1; rsv_rd = 9;
    #1;
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    step();
    chk("rst_we", rf_we, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err", err_double_rsv, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_wd", rf_wd, 0);
    idle();
    rst = 0;
    step();

    // single requester latency
    alu_valid = 1; alu_rd = 3; alu_wd = 32'hDEADBEEF;
    #1;
    chk("lat_alu_ready", alu_ready, 1);
    chk("lat_mem_ready", mem_ready, 0);
    step();
    idle();
    chk("lat_we1", rf_we, 1);
    chk("lat_rd1", rf_rd, 3);
    chk("lat_wd1", rf_wd, 32'hDEADBEEF);
    chk("lat_unrsv_pending", pending, 0);
    chk("lat_unrsv_err", err_double_rsv, 0);
    step();
    chk("lat_we2", rf_we, 0);
    chk("lat_rd_hold", rf_rd, 3);
    chk("lat_wd_hold", rf_wd, 32'hDEADBEEF);

    // contention fairness: m,m,m,m,a,m,m,m,m,a with no write bubble
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1; alu_rd = 10; alu_wd = 32'hA000 + i;
      mem_valid = 1; mem_rd = 11; mem_wd = 32'hB000 + i;
      exp_alu = (i == 4 || i == 9);
      #1;
      chk($sformatf("fair_alu_ready[%0d]", i), alu_ready, exp_alu);
      chk($sformatf("fair_mem_ready[%0d]", i), mem_ready, !exp_alu);
      step();
      chk($sformatf("fair_we[%0d]", i), rf_we, 1);
      chk($sformatf("fair_rd[%0d]", i), rf_rd, exp_alu ? 10 : 11);
      chk($sformatf("fair_wd[%0d]", i), rf_wd, exp_alu ? 32'hA000 + i : 32'hB000 + i);
    end
    idle();

    // uncontested mem grants hold the streak: build streak=3 first
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 10; mem_valid = 1; mem_rd = 11;
      #1;
      chk($sformatf("unc_pre_mem[%0d]", i), mem_ready, 1);
      step();
    end
    alu_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("unc_mem_only[%0d]", i), mem_ready, 1);
      step();
    end
    alu_valid = 1;
    #1;
    chk("unc_contested1_mem", mem_ready, 1);
    chk("unc_contested1_alu", alu_ready, 0);
    step();
    #1;
    chk("unc_contested2_alu", alu_ready, 1);
    chk("unc_contested2_mem", mem_ready, 0);
    step();
    idle();
    step();

    // x0 suppression
    mem_valid = 1; mem_rd = 0; mem_wd = 32'hFFFF;
    #1;
    chk("x0_mem_ready", mem_ready, 1);
    step();
    idle();
    chk("x0_we", rf_we, 0);
    chk("x0_rd_hold", rf_rd, 10);
    chk("x0_pending", pending, 0);

    // reserving x0 is ignored
    rsv_valid = 1; rsv_rd = 0;
    step();
    idle();
    chk("rsv_x0_pending", pending, 0);

    // scoreboard: cycle 0 reserve x7
    rsv_valid = 1; rsv_rd = 7;
    step();
    idle();
    chk("sb_set7", pending, 32'h80);
    step(); step(); step();
    // cycle 4: write x7 together with a new reservation of x7
    mem_valid = 1; mem_rd = 7; mem_wd = 32'h77;
    rsv_valid = 1; rsv_rd = 7;
    #1;
    chk("sb_c4_mem_ready", mem_ready, 1);
    step();
    idle();
    chk("sb_c5_pending", pending, 32'h80);
    chk("sb_c5_err", err_double_rsv, 0);
    chk("sb_c5_we", rf_we, 1);
    chk("sb_c5_rd", rf_rd, 7);
    step();
    // cycle 6: double reservation
    rsv_valid = 1; rsv_rd = 7;
    step();
    idle();
    chk("sb_c7_err", err_double_rsv, 1);
    chk("sb_c7_pending", pending, 32'h80);
    step(); step();
    chk("sb_err_sticky", err_double_rsv, 1);
    rst = 1;
    step();
    rst = 0;
    chk("sb_rst_err", err_double_rsv, 0);
    chk("sb_rst_pending", pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (rd/wd/we) between two writeback requesters: ALU results and load/memory results.
- Arbitrates between them, registers the winning write onto the port, and suppresses writes to x0.
- Keeps a 32-bit pending-write scoreboard, set at instruction issue and cleared at writeback, which the hazard unit uses for stall decisions.

Parameters:
MAX_STREAK, 4, number of consecutive contested cycles the memory requester may win before the ALU is granted once (range 1..15).
XLEN, 32, data width of write data.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_rd  in  5  ALU destination register
alu_wd  in  XLEN  ALU write data
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  memory/load writeback request
mem_rd  in  5  memory destination register
mem_wd  in  XLEN  memory write data
mem_ready  out  1  memory request accepted this cycle
rsv_valid  in  1  issue stage reserves a destination register
rsv_rd  in  5  register being reserved
rf_we  out  1  register file write enable (registered)
rf_rd  out  5  register file write address (registered)
rf_wd  out  XLEN  register file write data (registered)
pending  out  32  scoreboard; bit n set = write to xn outstanding
err_double_rsv  out  1  sticky: reservation of an already-pending register

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - rf_we=0, rf_rd=0, rf_wd=0, pending=0, err_double_rsv=0, streak counter=0.
  - An accepted write in the same cycle as rst is dropped.
  - alu_ready=0 and mem_ready=0 while rst=1.
- Handshake:
  - A request is accepted when valid&ready.
  - ready is combinational from the valids and the streak counter.
  - At most one requester is ready per cycle.
  - A requester holds valid/rd/wd stable until accepted.
- Arbitration:
  - Only alu_valid: alu_ready=1.
  - Only mem_valid: mem_ready=1.
  - Both valid (contested): mem wins unless streak==MAX_STREAK, in which case alu wins.
- Streak counter (4 bits):
  - Increments on a contested mem grant.
  - Clears to 0 on any alu grant.
  - Holds otherwise, including on an uncontested mem grant.
  - Saturates at MAX_STREAK.
- Write latency:
  - Accept in cycle N → rf_we=1 with rf_rd/rf_wd = accepted rd/wd during cycle N+1, for exactly one cycle unless another accept follows.
  - Back-to-back accepts give continuous rf_we with no bubble.
  - rf_rd/rf_wd hold their last values when rf_we=0.
- x0 suppression:
  - A request with rd=0 is arbitrated and accepted normally and consumes the grant.
  - rf_we stays 0 in cycle N+1.
- Scoreboard:
  - Set: rsv_valid=1 and rsv_rd≠0 → pending[rsv_rd]=1 at the next edge. rsv_rd=0 is ignored.
  - Clear: an accept with rd≠0 → pending[rd]=0 at the same edge as the accept, i.e. visible in cycle N+1 together with rf_we.
  - Same cycle, same register, set and clear: set wins and the bit stays 1. This covers back-to-back writers to one register where the writeback of the older instruction coincides with issue of the younger.
  - Double reservation: rsv_valid with pending[rsv_rd] already 1 and no same-cycle clear of that register → err_double_rsv=1 (sticky until rst); the bit stays 1.
  - Accepting a write for a register whose pending bit is 0 is legal (unreserved writeback): no error, bit stays 0.
- No combinational path from rsv_* to any output.

Test Plan:
- Reset mid-write: accept alu rd=5 wd=0x11 with rst=1 in the same cycle → next cycle rf_we=0, pending=0, err_double_rsv=0.
- Single requester latency: alu_valid, rd=3, wd=0xDEADBEEF in cycle 0 → alu_ready=1 in cycle 0; rf_we=1, rf_rd=3, rf_wd=0xDEADBEEF in cycle 1; rf_we=0 in cycle 2.
- Contention fairness: MAX_STREAK=4, both valid continuously with fresh data each accept → grant order mem,mem,mem,mem,alu,mem,mem,mem,mem,alu; rf_we high every cycle from cycle 1.
- Uncontested mem grants do not advance the streak: streak=3, then three mem-only cycles, then contested → mem wins once (streak reaches 4); the next contested cycle goes to alu.
- x0 suppression: mem_valid rd=0 wd=0xFFFF → mem_ready=1; rf_we=0 next cycle; pending unchanged.
- Scoreboard:
  - rsv rd=7 in cycle 0 → pending[7]=1 in cycle 1.
  - mem write rd=7 accepted in cycle 4 together with rsv rd=7 → pending[7] stays 1, err_double_rsv=0.
  - rsv rd=7 again in cycle 6 with no write to x7 → err_double_rsv=1 from cycle 7 and held until rst.
